core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 2: number of cycles core_reset is held after a start, legal range 1..15.
REQ-002 Parameter CW, default 16: width of the cycle counter.
REQ-003 Parameter TIMEOUT, default 16'd4096: RUN-state cycle limit, compared against cycle_count.
REQ-004 clk  input  1  single clock; all logic updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  host request to launch one program run; sampled each cycle.
REQ-007 core_done  input  1  done flag from the downstream processor top level.
REQ-008 core_reset  output  1  synchronous reset driven to the processor top level.
REQ-009 core_req  output  1  one-cycle request pulse driven to the processor's req input.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 finished  output  1  high when the last run ended with core_done.
REQ-012 timeout  output  1  high when the last run was aborted by the watchdog.
REQ-013 cycle_count  output  CW  number of REQ+RUN cycles in the current or last run.

Function
REQ-014 The block SHALL implement states IDLE, RST, REQ, RUN, DONE and TOUT, and all outputs SHALL be decoded from registered state only.
REQ-015 IDLE: core_reset=1, busy=0; start=1 -> RST, clear cycle_count and the RST counter.
REQ-016 RST: core_reset=1, busy=1; the state SHALL last exactly RST_CYCLES cycles, then -> REQ.
REQ-017 REQ: core_reset=0, core_req=1, busy=1; the state SHALL last one cycle, then -> RUN.
REQ-018 RUN: core_reset=0, busy=1; core_done=1 -> DONE.
REQ-019 RUN, watchdog compiled in: core_done=0 and cycle_count==TIMEOUT -> TOUT.
REQ-020 Counter rule: in REQ and RUN, cycle_count SHALL increment by 1 at each clock edge where core_done=0; otherwise it SHALL hold.
REQ-021 Counter rule: cycle_count SHALL saturate at all-ones and never wrap.
REQ-022 DONE: core_reset=0, finished=1, busy=0, cycle_count frozen; start=1 -> RST, clear finished and cycle_count.
REQ-023 TOUT: core_reset=1, timeout=1, busy=0, cycle_count frozen; start=1 -> RST, clear timeout and cycle_count.
REQ-024 start while in RST, REQ or RUN SHALL be ignored.
REQ-025 core_done while in IDLE, RST or REQ SHALL be ignored.
REQ-026 If core_done=1 and the timeout condition are true in the same cycle, done SHALL win and the next state SHALL be DONE.
REQ-027 finished and timeout SHALL never be high together.
REQ-028 core_req SHALL never be high while core_reset is high.

Reset
REQ-029 reset=1 SHALL force state IDLE on the next edge from any state, including mid-run.
REQ-030 Reset values: core_reset=1, core_req=0, busy=0, finished=0, timeout=0, cycle_count=0, RST counter=0.
REQ-031 reset SHALL take priority over start and core_done in the same cycle.

Configuration
REQ-032 Macro SEQ_WATCHDOG_EN defined: TOUT is reachable per REQ-019 and timeout behaves per REQ-023.
REQ-033 Macro SEQ_WATCHDOG_EN undefined: RUN waits indefinitely for core_done, TOUT logic is absent, timeout is tied 0, and cycle_count still saturates.

Verification
REQ-034 Parameters RST_CYCLES=2, TIMEOUT=20; start pulse in cycle 0 -> core_reset=1 in cycles 1-2, core_req=1 in cycle 3 only, busy=1 in cycles 1-3.
REQ-035 Same setup, core_done=1 in cycle 10 -> finished=1 from cycle 11, busy=0, cycle_count=7 held.
REQ-036 Watchdog compiled in, core_done held 0 -> cycle_count=20 in cycle 23, timeout=1 and core_reset=1 from cycle 24.
REQ-037 core_done=1 in cycle 23 with cycle_count=20 -> finished=1, timeout=0, next state DONE.
REQ-038 reset pulse in cycle 6 during RUN -> cycle 7 shows IDLE, core_reset=1 and cycle_count=0; start in cycle 4 and core_done in cycle 2 have no effect.
REQ-039 Watchdog compiled out, CW=4, core_done held 0 -> cycle_count saturates at 15 and stays there, timeout=0, busy=1.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: launches one program run on a downstream processor.
// Holds the core in reset for RST_CYCLES after a start, issues a single
// req pulse, then counts cycles until core_done. When the macro
// SEQ_WATCHDOG_EN is defined, a watchdog aborts the run once cycle_count
// reaches TIMEOUT; otherwise RUN waits indefinitely and timeout is tied 0.
//
// Handshake: start is a level sampled every cycle and only acts in IDLE,
// DONE or TOUT; core_done is a level sampled every cycle and only acts in RUN.
// All control outputs are registers loaded with the decode of the state
// being entered, so they always match the registered state.
module core_sequencer #(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned CW         = 16,
    parameter int unsigned TIMEOUT    = 16'd4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        REQ  = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4,
        TOUT = 3'd5
    } state_t;

    localparam logic [3:0]    RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};

    state_t     state;
    logic [3:0] rst_cnt;
    logic       count_sat;
    logic       count_inc;

    // Output decode for a state: {core_reset, core_req, busy, finished}.
    // core_req is only ever set where core_reset is clear.
    function automatic logic [3:0] outs(input state_t s);
        case (s)
            IDLE:    outs = 4'b1000;
            RST:     outs = 4'b1010;
            REQ:     outs = 4'b0110;
            RUN:     outs = 4'b0010;
            DONE:    outs = 4'b0001;
            TOUT:    outs = 4'b1000;
            default: outs = 4'b1000;
        endcase
    endfunction

    // The counter saturates rather than wrapping.
    assign count_sat = &cycle_count;
    assign count_inc = !core_done && !count_sat;

`ifdef SEQ_WATCHDOG_EN
    logic timeout_r;
    logic at_limit;

    // Compare at 32 bits so a TIMEOUT wider than CW can never match falsely.
    assign at_limit = (32'(cycle_count) == TIMEOUT);

    // timeout is set on entry to TOUT and cleared on reset or a new start.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_r <= 1'b0;
        end else if (state == RUN && !core_done && at_limit) begin
            timeout_r <= 1'b1;
        end else if (state == TOUT && start) begin
            timeout_r <= 1'b0;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // Sequencer FSM with registered outputs and the run cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            {core_reset, core_req, busy, finished} <= outs(IDLE);
            rst_cnt     <= 4'd0;
            cycle_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RST;
                        {core_reset, core_req, busy, finished} <= outs(RST);
                        rst_cnt     <= 4'd0;
                        cycle_count <= '0;
                    end
                end
                RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state <= REQ;
                        {core_reset, core_req, busy, finished} <= outs(REQ);
                    end else begin
                        rst_cnt <= rst_cnt + 4'd1;
                    end
                end
                REQ: begin
                    state <= RUN;
                    {core_reset, core_req, busy, finished} <= outs(RUN);
                    if (count_inc) begin
                        cycle_count <= cycle_count + ONE;
                    end
                end
                RUN: begin
                    if (count_inc) begin
                        cycle_count <= cycle_count + ONE;
                    end
                    // Done has priority over the watchdog in the same cycle.
                    if (core_done) begin
                        state <= DONE;
                        {core_reset, core_req, busy, finished} <= outs(DONE);
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (at_limit) begin
                        state <= TOUT;
                        {core_reset, core_req, busy, finished} <= outs(TOUT);
                    end
`endif
                end
                DONE: begin
                    if (start) begin
                        state       <= RST;
                        {core_reset, core_req, busy, finished} <= outs(RST);
                        rst_cnt     <= 4'd0;
                        cycle_count <= '0;
                    end
                end
`ifdef SEQ_WATCHDOG_EN
                TOUT: begin
                    if (start) begin
                        state       <= RST;
                        {core_reset, core_req, busy, finished} <= outs(RST);
                        rst_cnt     <= 4'd0;
                        cycle_count <= '0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    {core_reset, core_req, busy, finished} <= outs(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed testbench for core_sequencer. Cycle k is the interval after the
// k-th rising edge counted from the cycle in which start is driven (cycle 0).
// dut_a: RST_CYCLES=2, CW=16, TIMEOUT=20. dut_b: CW=4 for saturation.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, done_a, start_b, done_b;
    logic        a_core_reset, a_core_req, a_busy, a_finished, a_timeout;
    logic [15:0] a_count;
    logic        b_core_reset, b_core_req, b_busy, b_finished, b_timeout;
    logic [3:0]  b_count;

    int n_cmp = 0;
    int n_err = 0;

    core_sequencer #(.RST_CYCLES(2), .CW(16), .TIMEOUT(20)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .core_done(done_a),
        .core_reset(a_core_reset), .core_req(a_core_req), .busy(a_busy),
        .finished(a_finished), .timeout(a_timeout), .cycle_count(a_count)
    );

    core_sequencer #(.RST_CYCLES(2), .CW(4), .TIMEOUT(20)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .core_done(done_b),
        .core_reset(b_core_reset), .core_req(b_core_req), .busy(b_busy),
        .finished(b_finished), .timeout(b_timeout), .cycle_count(b_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Checking task: counts every comparison and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; done_a = 1'b0; start_b = 1'b0; done_b = 1'b0;
        steps(2);
        check("rst_core_reset", a_core_reset, 1);
        check("rst_core_req", a_core_req, 0);
        check("rst_busy", a_busy, 0);
        check("rst_finished", a_finished, 0);
        check("rst_timeout", a_timeout, 0);
        check("rst_count", a_count, 0);
        check("rst_b_count", b_count, 0);
        reset = 1'b0;
        step();

        // core_done ignored in IDLE
        done_a = 1'b1;
        step();
        done_a = 1'b0;
        check("idle_done_busy", a_busy, 0);
        check("idle_done_finished", a_finished, 0);

        // Basic run: start in cycle 0, done in cycle 10
        start_a = 1'b1;
        step();                              // cycle 1
        start_a = 1'b0;
        check("c1_core_reset", a_core_reset, 1);
        check("c1_busy", a_busy, 1);
        check("c1_core_req", a_core_req, 0);
        step();                              // cycle 2
        check("c2_core_reset", a_core_reset, 1);
        check("c2_core_req", a_core_req, 0);
        step();                              // cycle 3
        check("c3_core_req", a_core_req, 1);
        check("c3_core_reset", a_core_reset, 0);
        check("c3_busy", a_busy, 1);
        check("c3_count", a_count, 0);
        step();                              // cycle 4
        check("c4_core_req", a_core_req, 0);
        check("c4_count", a_count, 1);
        steps(6);                            // cycle 10
        check("c10_count", a_count, 7);
        done_a = 1'b1;
        step();                              // cycle 11
        done_a = 1'b0;
        check("c11_finished", a_finished, 1);
        check("c11_busy", a_busy, 0);
        check("c11_count", a_count, 7);
        check("c11_core_reset", a_core_reset, 0);
        check("c11_timeout", a_timeout, 0);
        steps(3);
        check("done_hold_count", a_count, 7);
        check("done_hold_finished", a_finished, 1);

        // Restart from DONE; done in RST and start in RUN ignored; reset mid-run
        start_a = 1'b1;
        step();                              // cycle 1
        start_a = 1'b0;
        check("rs_c1_finished", a_finished, 0);
        check("rs_c1_count", a_count, 0);
        check("rs_c1_busy", a_busy, 1);
        step();                              // cycle 2
        done_a = 1'b1;
        step();                              // cycle 3
        done_a = 1'b0;
        check("rs_c3_core_req", a_core_req, 1);
        check("rs_c3_finished", a_finished, 0);
        step();                              // cycle 4
        start_a = 1'b1;
        step();                              // cycle 5
        start_a = 1'b0;
        check("rs_c5_busy", a_busy, 1);
        check("rs_c5_core_reset", a_core_reset, 0);
        check("rs_c5_count", a_count, 2);
        step();                              // cycle 6
        reset = 1'b1;
        done_a = 1'b1;
        step();                              // cycle 7
        reset = 1'b0;
        done_a = 1'b0;
        check("rs_c7_core_reset", a_core_reset, 1);
        check("rs_c7_busy", a_busy, 0);
        check("rs_c7_count", a_count, 0);
        check("rs_c7_finished", a_finished, 0);
        check("rs_c7_core_req", a_core_req, 0);

`ifdef SEQ_WATCHDOG_EN
        // Watchdog abort with core_done held low
        start_a = 1'b1;
        step();                              // cycle 1
        start_a = 1'b0;
        steps(22);                           // cycle 23
        check("wd_c23_count", a_count, 20);
        check("wd_c23_timeout", a_timeout, 0);
        check("wd_c23_busy", a_busy, 1);
        step();                              // cycle 24
        check("wd_c24_timeout", a_timeout, 1);
        check("wd_c24_core_reset", a_core_reset, 1);
        check("wd_c24_busy", a_busy, 0);
        check("wd_c24_finished", a_finished, 0);
        check("wd_c24_core_req", a_core_req, 0);
        steps(2);
        check("wd_hold_timeout", a_timeout, 1);

        // Done and timeout coincide: done wins
        start_a = 1'b1;
        step();                              // cycle 1
        start_a = 1'b0;
        check("wd2_c1_timeout", a_timeout, 0);
        check("wd2_c1_busy", a_busy, 1);
        steps(22);                           // cycle 23
        check("wd2_c23_count", a_count, 20);
        done_a = 1'b1;
        step();                              // cycle 24
        done_a = 1'b0;
        check("wd2_c24_finished", a_finished, 1);
        check("wd2_c24_timeout", a_timeout, 0);
        check("wd2_c24_count", a_count, 20);
        check("wd2_c24_busy", a_busy, 0);
`else
        // No watchdog: run continues past TIMEOUT
        start_a = 1'b1;
        step();                              // cycle 1
        start_a = 1'b0;
        steps(23);                           // cycle 24
        check("nwd_c24_timeout", a_timeout, 0);
        check("nwd_c24_busy", a_busy, 1);
        check("nwd_c24_count", a_count, 21);
        steps(20);                           // cycle 44
        check("nwd_c44_count", a_count, 41);
        check("nwd_c44_core_reset", a_core_reset, 0);
        done_a = 1'b1;
        step();
        done_a = 1'b0;
        check("nwd_done_finished", a_finished, 1);
        check("nwd_done_count", a_count, 41);
`endif

        // Saturation on the 4-bit counter
        start_b = 1'b1;
        step();                              // cycle 1
        start_b = 1'b0;
        steps(17);                           // cycle 18
        check("sat_c18_count", b_count, 15);
        check("sat_c18_busy", b_busy, 1);
        steps(12);                           // cycle 30
        check("sat_c30_count", b_count, 15);
        check("sat_c30_busy", b_busy, 1);
        check("sat_c30_timeout", b_timeout, 0);
        done_b = 1'b1;
        step();
        done_b = 1'b0;
        check("sat_done_finished", b_finished, 1);
        check("sat_done_count", b_count, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
